// File: rtl/upgrade_pickup_mgr_pkg.sv
// Shared types and helpers for the upgrade pickup manager.
// Optional award stacking is enabled with UPGRADE_STACK_EN.
package upgrade_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        UPG_SPEED,
        UPG_SIZE,
        UPG_SHIELD
    } upg_type_e;

    typedef enum logic {
        SLOT_ACTIVE,
        SLOT_COOLDOWN
    } slot_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Inclusive |b-c| <= r, widened by one bit so screen edges never wrap.
    function automatic logic in_box(
        input logic [COORD_W-1:0] bv,
        input logic [COORD_W-1:0] cv,
        input logic [COORD_W-1:0] rv
    );
        logic [COORD_W:0] b;
        logic [COORD_W:0] c;
        logic [COORD_W:0] r;
        b = {1'b0, bv};
        c = {1'b0, cv};
        r = {1'b0, rv};
        return (b + r >= c) && (b <= c + r);
    endfunction

endpackage

// File: rtl/upgrade_pickup_mgr_if.sv
// Playfield geometry in, slot/effect status and collection strobe out.
interface upgrade_pickup_mgr_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_SLOTS   = 4,
    parameter int NUM_TYPES   = 3
);
    import upgrade_pkg::*;

    localparam int PW = idx_w(NUM_PLAYERS);
    localparam int SW = idx_w(NUM_SLOTS);
    localparam int TW = idx_w(NUM_TYPES);

    logic [NUM_PLAYERS-1:0][COORD_W-1:0] ball_x;
    logic [NUM_PLAYERS-1:0][COORD_W-1:0] ball_y;
    logic [COORD_W-1:0]                  ball_size;
    logic [NUM_SLOTS-1:0][COORD_W-1:0]   upg_x;
    logic [NUM_SLOTS-1:0][COORD_W-1:0]   upg_y;
    logic [NUM_SLOTS-1:0][TW-1:0]        upg_type;
    logic [COORD_W-1:0]                  upg_size;
    logic [NUM_SLOTS-1:0]                slot_active;
    logic [NUM_PLAYERS-1:0][NUM_TYPES-1:0] effect_active;
    logic                                collect_pulse;
    logic [PW-1:0]                       collect_player;
    logic [SW-1:0]                       collect_slot;

    modport master (
        output ball_x, ball_y, ball_size,
        output upg_x, upg_y, upg_type, upg_size,
        input  slot_active, effect_active,
        input  collect_pulse, collect_player, collect_slot
    );

    modport slave (
        input  ball_x, ball_y, ball_size,
        input  upg_x, upg_y, upg_type, upg_size,
        output slot_active, effect_active,
        output collect_pulse, collect_player, collect_slot
    );

endinterface

// File: rtl/upgrade_pickup_mgr_slot.sv
// One upgrade slot: player hit test, lowest-index arbitration,
// active/cooldown FSM and respawn counter.
module upgrade_slot
    import upgrade_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int RESPAWN     = 300,
    parameter int CNT_W       = 12,
    localparam int PW         = idx_w(NUM_PLAYERS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PLAYERS-1:0][COORD_W-1:0] ball_x,
    input  logic [NUM_PLAYERS-1:0][COORD_W-1:0] ball_y,
    input  logic [COORD_W-1:0]                  upg_x,
    input  logic [COORD_W-1:0]                  upg_y,
    input  logic [COORD_W-1:0]                  upg_size,
    output logic                                active,
    output logic                                award,
    output logic [PW-1:0]                       winner
);

    localparam logic [CNT_W-1:0] RLOAD =
        CNT_W'((RESPAWN > 0) ? RESPAWN - 1 : 0);

    slot_state_e            state;
    slot_state_e            state_n;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_n;
    logic [NUM_PLAYERS-1:0] hit;

    always_comb begin
        hit    = '0;
        winner = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            hit[p] = in_box(ball_x[p], upg_x, upg_size) &&
                     in_box(ball_y[p], upg_y, upg_size);
        end
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (hit[p]) winner = PW'(p);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SLOT_ACTIVE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // RESPAWN of zero leaves the slot parked in cooldown until reset.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            SLOT_ACTIVE: begin
                if (|hit) begin
                    state_n = SLOT_COOLDOWN;
                    cnt_n   = RLOAD;
                end
            end
            SLOT_COOLDOWN: begin
                if (RESPAWN != 0) begin
                    if (cnt == '0) state_n = SLOT_ACTIVE;
                    else           cnt_n   = cnt - 1'b1;
                end
            end
            default: state_n = SLOT_ACTIVE;
        endcase
    end

    always_comb begin
        active = (state == SLOT_ACTIVE);
        award  = active && (|hit);
    end

endmodule

// File: rtl/upgrade_pickup_mgr.sv
// Multi-player, multi-slot pickup manager with timed per-type effects.
// Define UPGRADE_STACK_EN to make awards add to the remaining time.
module upgrade_pickup_mgr
    import upgrade_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_SLOTS   = 4,
    parameter int NUM_TYPES   = 3,
    parameter int DURATION    = 600,
    parameter int RESPAWN     = 300,
    parameter int CNT_W       = 12
) (
    input logic           frame_clk,
    input logic           Reset,
    upgrade_pickup_mgr_if.slave bus
);

    localparam int PW = idx_w(NUM_PLAYERS);
    localparam int SW = idx_w(NUM_SLOTS);
    localparam int TW = idx_w(NUM_TYPES);
    localparam bit PERM = (DURATION == 0);
    localparam logic [CNT_W-1:0] DUR = CNT_W'(DURATION);

    logic [NUM_SLOTS-1:0] active;
    logic [NUM_SLOTS-1:0] award;
    logic [PW-1:0]        winner [NUM_SLOTS];

    logic [NUM_PLAYERS-1:0][NUM_TYPES-1:0] grant;
    logic [CNT_W-1:0] cnt  [NUM_PLAYERS][NUM_TYPES];
    logic [CNT_W-1:0] load [NUM_PLAYERS][NUM_TYPES];
    logic [SW-1:0]    first_slot;
    logic [PW-1:0]    first_player;
    logic             unused_ball_size;

    assign unused_ball_size = ^bus.ball_size;

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        upgrade_slot #(
            .NUM_PLAYERS(NUM_PLAYERS),
            .RESPAWN    (RESPAWN),
            .CNT_W      (CNT_W)
        ) u_slot (
            .clk     (frame_clk),
            .rst     (Reset),
            .ball_x  (bus.ball_x),
            .ball_y  (bus.ball_y),
            .upg_x   (bus.upg_x[s]),
            .upg_y   (bus.upg_y[s]),
            .upg_size(bus.upg_size),
            .active  (active[s]),
            .award   (award[s]),
            .winner  (winner[s])
        );
    end

    assign bus.slot_active = active;

    // Several same-type awards to one player in a frame merge into one grant.
    always_comb begin
        grant = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                for (int t = 0; t < NUM_TYPES; t++) begin
                    if (award[s] && winner[s] == PW'(p) &&
                        bus.upg_type[s] == TW'(t))
                        grant[p][t] = 1'b1;
                end
            end
        end
    end

    always_comb begin
`ifdef UPGRADE_STACK_EN
        logic [CNT_W:0] sum;
`endif
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int t = 0; t < NUM_TYPES; t++) begin
`ifdef UPGRADE_STACK_EN
                sum = {1'b0, cnt[p][t]} + {1'b0, DUR};
                load[p][t] = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
`else
                load[p][t] = DUR;
`endif
                if (PERM) load[p][t] = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge frame_clk) begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int t = 0; t < NUM_TYPES; t++) begin
                if (Reset)
                    cnt[p][t] <= '0;
                else if (grant[p][t])
                    cnt[p][t] <= load[p][t];
                else if (!PERM && cnt[p][t] != '0)
                    cnt[p][t] <= cnt[p][t] - 1'b1;
            end
        end
    end

    always_comb begin
        bus.effect_active = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int t = 0; t < NUM_TYPES; t++) begin
                bus.effect_active[p][t] = (cnt[p][t] != '0);
            end
        end
    end

    always_comb begin
        first_slot   = '0;
        first_player = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (award[s]) begin
                first_slot   = SW'(s);
                first_player = winner[s];
            end
        end
    end

    // Reported player/slot hold their last value between collections.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            bus.collect_pulse  <= 1'b0;
            bus.collect_player <= '0;
            bus.collect_slot   <= '0;
        end else begin
            bus.collect_pulse <= |award;
            if (|award) begin
                bus.collect_player <= first_player;
                bus.collect_slot   <= first_slot;
            end
        end
    end

endmodule

// File: tb/tb_upgrade_pickup_mgr.sv
// Directed bench: timed-effect instance plus a permanent/no-respawn instance.
module tb_upgrade_pickup_mgr;
    import upgrade_pkg::*;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    upgrade_pickup_mgr_if #(.NUM_PLAYERS(2), .NUM_SLOTS(4), .NUM_TYPES(3)) ia ();
    upgrade_pickup_mgr_if #(.NUM_PLAYERS(2), .NUM_SLOTS(4), .NUM_TYPES(3)) ib ();

    upgrade_pickup_mgr #(
        .NUM_PLAYERS(2), .NUM_SLOTS(4), .NUM_TYPES(3),
        .DURATION(5), .RESPAWN(3), .CNT_W(12)
    ) dut_a (
        .frame_clk(clk),
        .Reset    (rst_a),
        .bus      (ia)
    );

    upgrade_pickup_mgr #(
        .NUM_PLAYERS(2), .NUM_SLOTS(4), .NUM_TYPES(3),
        .DURATION(0), .RESPAWN(0), .CNT_W(12)
    ) dut_b (
        .frame_clk(clk),
        .Reset    (rst_b),
        .bus      (ib)
    );

`ifdef UPGRADE_STACK_EN
    localparam int RETAKE_HIGH = 6;
    localparam int STACK_HIGH  = 7;
`else
    localparam int RETAKE_HIGH = 4;
    localparam int STACK_HIGH  = 4;
`endif

    typedef struct {
        logic [9:0] x0, y0, x1, y1;
        logic [3:0] act;
        logic [5:0] eff;
        logic       pulse;
        logic       pl;
        logic [1:0] sl;
    } vec_t;

    vec_t tv[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic park();
        ia.ball_x = {10'd900, 10'd900};
        ia.ball_y = {10'd700, 10'd700};
        ib.ball_x = {10'd900, 10'd900};
        ib.ball_y = {10'd700, 10'd700};
    endtask

    task automatic reset_a();
        park();
        rst_a = 1'b1;
        tick();
        tick();
        rst_a = 1'b0;
    endtask

    task automatic count_high(output int n);
        n = 0;
        tick();
        while (ia.effect_active[0][0] && n < 20) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        // slot0 (102,98) SPEED, slot1 (300,300) SIZE,
        // slot2 (2,2) SHIELD, slot3 (500,400) SPEED, all size 4
        ia.upg_x    = {10'd500, 10'd2, 10'd300, 10'd102};
        ia.upg_y    = {10'd400, 10'd2, 10'd300, 10'd98};
        ia.upg_type = {UPG_SPEED, UPG_SHIELD, UPG_SIZE, UPG_SPEED};
        ia.upg_size = 10'd4;
        ia.ball_size = 10'd8;
        ib.upg_x    = ia.upg_x;
        ib.upg_y    = ia.upg_y;
        ib.upg_type = ia.upg_type;
        ib.upg_size = 10'd4;
        ib.ball_size = 10'd8;

        tv[0]  = '{100, 100, 900, 700, 4'b1110, 6'b000_001, 1, 0, 0};
        tv[1]  = '{900, 700, 900, 700, 4'b1110, 6'b000_001, 0, 0, 0};
        tv[2]  = '{300, 300, 300, 300, 4'b1100, 6'b000_011, 1, 0, 1};
        tv[3]  = '{900, 700,   0,   0, 4'b1001, 6'b100_011, 1, 1, 2};
        tv[4]  = '{500, 400, 102,  98, 4'b0000, 6'b101_011, 1, 1, 0};
        tv[5]  = '{900, 700, 900, 700, 4'b0010, 6'b101_011, 0, 1, 0};
        tv[6]  = '{900, 700, 900, 700, 4'b0110, 6'b101_011, 0, 1, 0};
        tv[7]  = '{900, 700, 900, 700, 4'b1111, 6'b101_001, 0, 1, 0};
        tv[8]  = '{  7,   2, 900, 700, 4'b1111, 6'b001_001, 0, 1, 0};
        tv[9]  = '{  6,   2,   2,   7, 4'b1011, 6'b000_100, 1, 0, 2};
        tv[10] = '{900, 700,   2,   2, 4'b1011, 6'b000_100, 0, 0, 2};
        tv[11] = '{ 98, 102, 900, 700, 4'b1010, 6'b000_101, 1, 0, 0};

        rst_b = 1'b1;
        reset_a();
        rst_b = 1'b0;
        chk("rst_active", ia.slot_active, 4'b1111);
        chk("rst_effect", ia.effect_active, 6'b0);
        chk("rst_pulse", ia.collect_pulse, 1'b0);
        chk("rst_player", ia.collect_player, 1'b0);
        chk("rst_slot", ia.collect_slot, 2'd0);
        chk("rst_b_active", ib.slot_active, 4'b1111);

        for (int i = 0; i < 12; i++) begin
            ia.ball_x = {tv[i].x1, tv[i].x0};
            ia.ball_y = {tv[i].y1, tv[i].y0};
            tick();
            chk($sformatf("v%0d_active", i), ia.slot_active, tv[i].act);
            chk($sformatf("v%0d_effect", i), ia.effect_active, tv[i].eff);
            chk($sformatf("v%0d_pulse", i), ia.collect_pulse, tv[i].pulse);
            chk($sformatf("v%0d_player", i), ia.collect_player, tv[i].pl);
            chk($sformatf("v%0d_slot", i), ia.collect_slot, tv[i].sl);
        end

        // lifetime and respawn timing, then retake of the respawned slot
        reset_a();
        ia.ball_x[0] = 10'd100;
        ia.ball_y[0] = 10'd100;
        tick();
        park();
        chk("dur_k_eff", ia.effect_active[0][0], 1'b1);
        chk("dur_k_act", ia.slot_active[0], 1'b0);
        tick();
        chk("dur_k1_act", ia.slot_active[0], 1'b0);
        tick();
        chk("dur_k2_act", ia.slot_active[0], 1'b0);
        tick();
        chk("dur_k3_act", ia.slot_active[0], 1'b1);
        chk("dur_k3_eff", ia.effect_active[0][0], 1'b1);
        ia.ball_x[0] = 10'd100;
        ia.ball_y[0] = 10'd100;
        tick();
        park();
        chk("retake_pulse", ia.collect_pulse, 1'b1);
        chk("retake_act", ia.slot_active[0], 1'b0);
        count_high(n);
        chk("retake_high_frames", n, RETAKE_HIGH);

        // pure lifetime: collect once, count frames the effect stays up
        reset_a();
        ia.ball_x[0] = 10'd100;
        ia.ball_y[0] = 10'd100;
        tick();
        park();
        chk("life_eff", ia.effect_active[0][0], 1'b1);
        count_high(n);
        chk("life_high_frames", n, 4);

        // second SPEED slot taken while counter holds 3
        reset_a();
        ia.ball_x[0] = 10'd100;
        ia.ball_y[0] = 10'd100;
        tick();
        park();
        tick();
        tick();
        ia.ball_x[0] = 10'd500;
        ia.ball_y[0] = 10'd400;
        tick();
        park();
        chk("stack_pulse", ia.collect_pulse, 1'b1);
        chk("stack_slot", ia.collect_slot, 2'd3);
        count_high(n);
        chk("stack_high_frames", n, STACK_HIGH);

        // permanent effect, no respawn, reset mid-run
        ib.ball_x[0] = 10'd100;
        ib.ball_y[0] = 10'd100;
        tick();
        park();
        for (int f = 0; f < 499; f++) begin
            chk("perm_act", ib.slot_active[0], 1'b0);
            chk("perm_eff", ib.effect_active[0][0], 1'b1);
            tick();
        end
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        chk("perm_rst_act", ib.slot_active, 4'b1111);
        chk("perm_rst_eff", ib.effect_active, 6'b0);
        chk("perm_rst_pulse", ib.collect_pulse, 1'b0);
        for (int f = 0; f < 500; f++) begin
            tick();
        end
        chk("perm_after_act", ib.slot_active, 4'b1111);
        chk("perm_after_eff", ib.effect_active, 6'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
